// File: rtl/pwm_led_bank.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_led_bank
//  Function : CHANNELS-output PWM LED driver sharing one prescaled period
//             counter; per-channel duty applied at period boundaries with an
//             optional linear fade toward the written target.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_led_bank #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 8,
    parameter int CH_BITS   = 2,
    parameter int PRESCALE  = 1,
    parameter int FADE_STEP = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic                wr_fade,
    output logic [CHANNELS-1:0] led_out,
    output logic [CHANNELS-1:0] fading,
    output logic                period_start
);

    localparam int                c_PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(PRESCALE - 1);
    localparam logic [WIDTH:0]    c_STEP   = (WIDTH + 1)'(FADE_STEP);

    logic [c_PS_W-1:0]               r_prescale;
    logic [WIDTH-1:0]                r_count;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_target;
    logic [CHANNELS-1:0][WIDTH-1:0]  r_active;
    logic [CHANNELS-1:0]             r_mode;

    logic                            w_tick;
    logic                            w_boundary;
    logic [CHANNELS-1:0][WIDTH-1:0]  w_next;
    logic [CHANNELS-1:0]             w_raw;
    logic [CHANNELS-1:0]             w_wr_hit;

    assign w_tick     = (r_prescale == c_PS_MAX);
    assign w_boundary = w_tick && (r_count == {WIDTH{1'b1}});

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH:0]   w_act_ext;
            logic [WIDTH:0]   w_tgt_ext;
            logic [WIDTH:0]   w_up_sum;
            logic [WIDTH:0]   w_dn_diff;
            logic [WIDTH-1:0] w_up;
            logic [WIDTH-1:0] w_dn;

            // One extra bit keeps the ramp arithmetic free of wrap/underflow
            assign w_act_ext = {1'b0, r_active[gi]};
            assign w_tgt_ext = {1'b0, r_target[gi]};
            assign w_up_sum  = w_act_ext + c_STEP;
            assign w_dn_diff = w_act_ext - c_STEP;

            assign w_up = (w_up_sum > w_tgt_ext) ? r_target[gi] : w_up_sum[WIDTH-1:0];
            assign w_dn = ((w_act_ext < c_STEP) || (w_dn_diff < w_tgt_ext))
                          ? r_target[gi] : w_dn_diff[WIDTH-1:0];

            assign w_next[gi] = !r_mode[gi]              ? r_target[gi] :
                                (w_tgt_ext > w_act_ext)  ? w_up :
                                (w_tgt_ext < w_act_ext)  ? w_dn :
                                                           r_active[gi];

            // Full-scale duty is forced on so the counter==max tick stays lit
            assign w_raw[gi]    = (r_active[gi] == {WIDTH{1'b1}}) || (r_count < r_active[gi]);
            assign w_wr_hit[gi] = wr_en && (wr_ch == CH_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prescale   <= '0;
            r_count      <= '0;
            r_target     <= '0;
            r_active     <= '0;
            r_mode       <= '0;
            led_out      <= '0;
            fading       <= '0;
            period_start <= 1'b0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            if (w_tick) begin
                r_count <= r_count + 1'b1;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_boundary) begin
                    r_active[i] <= w_next[i];
                end
                if (w_wr_hit[i]) begin
                    r_target[i] <= wr_duty;
                    r_mode[i]   <= wr_fade;
                end
                fading[i] <= (r_active[i] != r_target[i]);
            end
            led_out      <= w_raw;
            period_start <= w_boundary;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_led_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_led_bank
//  Function : Self-checking bench for pwm_led_bank (step 1 / step 3 / prescale 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_led_bank;

    logic       clk = 1'b0;
    logic       reset_n, reset_p_n, wr_en, wr_fade;
    logic [2:0] wr_ch;
    logic [7:0] wr_duty;
    logic [3:0] led_a, fad_a, led_b, fad_b, led_p, fad_p;
    logic       ps_a, ps_b, ps_p;

    always #5 clk = ~clk;

    pwm_led_bank #(.CHANNELS(4), .WIDTH(8), .CH_BITS(3), .PRESCALE(1), .FADE_STEP(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .wr_fade(wr_fade), .led_out(led_a), .fading(fad_a), .period_start(ps_a));

    pwm_led_bank #(.CHANNELS(4), .WIDTH(8), .CH_BITS(3), .PRESCALE(1), .FADE_STEP(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .wr_fade(wr_fade), .led_out(led_b), .fading(fad_b), .period_start(ps_b));

    pwm_led_bank #(.CHANNELS(4), .WIDTH(8), .CH_BITS(3), .PRESCALE(4), .FADE_STEP(1)) dut_p (
        .clk(clk), .reset_n(reset_p_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .wr_fade(wr_fade), .led_out(led_p), .fading(fad_p), .period_start(ps_p));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h required 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model of the boundary duty update, parametrised by fade step
    function automatic logic [7:0] f_step(input logic [7:0] act, input logic [7:0] tgt,
                                          input logic mode, input int fs);
        int a;
        int t;
        a = int'(act);
        t = int'(tgt);
        if (!mode || a == t) return tgt;
        if (t > a) return (a + fs >= t) ? tgt : 8'(a + fs);
        return (a - fs <= t) ? tgt : 8'(a - fs);
    endfunction

    function automatic logic [8:0] f_hi(input logic [7:0] act);
        return (act == 8'hFF) ? 9'd256 : {1'b0, act};
    endfunction

    typedef struct packed {
        logic [3:0][8:0] a;
        logic [3:0][8:0] b;
    } win_t;

    win_t            sb_q[$];
    win_t            sb_e;
    logic [3:0][7:0] m_tgt, m_act_a, m_act_b, m_na, m_nb;
    logic [3:0]      m_mode, m_fe_a, m_fe_b;
    logic [3:0][8:0] cnt_a, cnt_b, m_ca, m_cb;
    logic            armed = 1'b0;
    logic            m_in_rst = 1'b1;
    logic            pend_v = 1'b0;
    logic [1:0]      pend_ch;
    logic [7:0]      pend_duty;
    logic            pend_fade;

    // Capture what the DUTs see on each active edge
    always @(posedge clk) begin
        m_in_rst  <= !reset_n;
        pend_v    <= reset_n && wr_en && (wr_ch < 3'd4);
        pend_ch   <= wr_ch[1:0];
        pend_duty <= wr_duty;
        pend_fade <= wr_fade;
    end

    // Per-period high-count scoreboard plus per-cycle fading check
    always @(negedge clk) begin
        if (m_in_rst) begin
            m_tgt   <= '0;
            m_act_a <= '0;
            m_act_b <= '0;
            m_mode  <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            armed   <= 1'b0;
            sb_q.delete();
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_fe_a[c] = (m_act_a[c] != m_tgt[c]);
                m_fe_b[c] = (m_act_b[c] != m_tgt[c]);
                m_ca[c]   = cnt_a[c] + 9'(led_a[c]);
                m_cb[c]   = cnt_b[c] + 9'(led_b[c]);
            end
            chk_eq("fading_a", fad_a, m_fe_a);
            chk_eq("fading_b", fad_b, m_fe_b);
            if (ps_a) begin
                if (armed) begin
                    chk_eq("sb_depth", sb_q.size(), 1);
                    if (sb_q.size() > 0) begin
                        sb_e = sb_q.pop_front();
                        chk_eq("window_a", m_ca, sb_e.a);
                        chk_eq("window_b", m_cb, sb_e.b);
                    end
                end
                for (int c = 0; c < 4; c++) begin
                    m_na[c]   = f_step(m_act_a[c], m_tgt[c], m_mode[c], 1);
                    m_nb[c]   = f_step(m_act_b[c], m_tgt[c], m_mode[c], 3);
                    sb_e.a[c] = f_hi(m_na[c]);
                    sb_e.b[c] = f_hi(m_nb[c]);
                end
                sb_q.push_back(sb_e);
                m_act_a <= m_na;
                m_act_b <= m_nb;
                armed   <= 1'b1;
                cnt_a   <= '0;
                cnt_b   <= '0;
            end else begin
                cnt_a <= m_ca;
                cnt_b <= m_cb;
            end
            if (pend_v) begin
                m_tgt[pend_ch]  <= pend_duty;
                m_mode[pend_ch] <= pend_fade;
            end
        end
    end

    // Caller is positioned at a negedge; returns at the negedge after the write lands
    task automatic wr(input logic [2:0] ch, input logic [7:0] duty, input logic fade);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_duty = duty;
        wr_fade = fade;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_ps(input bit use_p, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(use_p ? ps_p : ps_a) && n < limit);
        if (!(use_p ? ps_p : ps_a)) chk_eq(use_p ? "ps_timeout_p" : "ps_timeout_a", 0, 1);
    endtask

    int n;
    int sum;

    initial begin
        reset_n   = 1'b0;
        reset_p_n = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_duty   = '0;
        wr_fade   = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_led", led_a, 0);
        chk_eq("rst_fading", fad_a, 0);
        chk_eq("rst_ps", ps_a, 0);
        reset_n = 1'b1;
        wait_ps(0, 300, n);
        chk_eq("first_ps_delay", n, 256);

        // Immediate duty on ch1
        repeat (10) @(negedge clk);
        wr(3'd1, 8'd64, 1'b0);
        @(negedge clk);
        chk_eq("imm_fading", fad_a[1], 1);
        wait_ps(0, 300, n);
        @(negedge clk);
        chk_eq("imm_first_hi", led_a[1], 1);
        repeat (63) @(negedge clk);
        chk_eq("imm_last_hi", led_a[1], 1);
        @(negedge clk);
        chk_eq("imm_first_lo", led_a[1], 0);
        chk_eq("imm_fading_clr", fad_a[1], 0);

        // Extremes on ch0
        wr(3'd0, 8'd255, 1'b0);
        wait_ps(0, 300, n);
        wait_ps(0, 300, n);
        chk_eq("full_on_cnt255", led_a[0], 1);
        wr(3'd0, 8'd0, 1'b0);
        wait_ps(0, 300, n);
        wait_ps(0, 300, n);
        chk_eq("zero_duty_cnt255", led_a[0], 0);

        // Fade ch2 0 -> 4 (step 1 on dut_a, step 3 on dut_b)
        repeat (5) @(negedge clk);
        wr(3'd2, 8'd4, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            wait_ps(0, 300, n);
            @(negedge clk);
            if (k == 2) begin
                chk_eq("fade_b_done", fad_b[2], 0);
                chk_eq("fade_a_busy", fad_a[2], 1);
            end
        end
        chk_eq("fade_a_done", fad_a[2], 0);
        wait_ps(0, 300, n);

        // Write on the boundary cycle takes effect one period later
        wait_ps(0, 300, n);
        repeat (255) @(negedge clk);
        wr(3'd3, 8'd100, 1'b0);
        chk_eq("collide_ps", ps_a, 1);
        @(negedge clk);
        chk_eq("collide_old", led_a[3], 0);
        wait_ps(0, 300, n);
        @(negedge clk);
        chk_eq("collide_new", led_a[3], 1);

        // Out-of-range channel is ignored
        wr(3'd5, 8'd200, 1'b1);
        @(negedge clk);
        chk_eq("illegal_ch_fading", fad_a, 0);
        wait_ps(0, 300, n);
        wait_ps(0, 300, n);

        // PRESCALE=4 instance: duty, reset mid-fade, period length
        reset_p_n = 1'b1;
        wr(3'd0, 8'd10, 1'b0);
        wait_ps(1, 1100, n);
        sum = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            sum += int'(led_p[0]);
        end
        chk_eq("p4_duty10", sum, 40);
        chk_eq("p4_period", ps_p, 1);
        wr(3'd0, 8'd200, 1'b1);
        wait_ps(1, 1100, n);
        @(negedge clk);
        chk_eq("p4_fading", fad_p[0], 1);
        repeat (19) @(negedge clk);
        chk_eq("p4_led_pre_rst", led_p[0], 1);
        reset_p_n = 1'b0;
        @(negedge clk);
        chk_eq("p4_rst_led", led_p, 0);
        chk_eq("p4_rst_fading", fad_p, 0);
        chk_eq("p4_rst_ps", ps_p, 0);
        @(negedge clk);
        reset_p_n = 1'b1;
        wait_ps(1, 1100, n);
        chk_eq("p4_first_ps_delay", n, 1024);
        sum = 0;
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            sum += int'(led_p[0]);
        end
        chk_eq("p4_no_residual", sum, 0);
        chk_eq("p4_period_after_rst", ps_p, 1);
        chk_eq("p4_fading_after_rst", fad_p, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
